// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and limits for the pipeline hazard control unit.
//   hazard_state_t       : controller state; the numeric values are visible
//                          on the debug port, so they are pinned explicitly.
//   LOAD_USE_BUBBLES_MAX : largest legal number of load-use bubbles.
//   BUB_CNT_W            : width of the remaining-bubble counter.
//   loadUseHazard()      : Decode-vs-Execute load dependency compare.
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2
  } hazard_state_t;

  localparam int LOAD_USE_BUBBLES_MAX = 3;
  localparam int BUB_CNT_W            = 2;

  // $0 is hard-wired to zero, so a load targeting it never creates a
  // dependency. rt only matters when the Decode instruction reads it.
  function automatic logic loadUseHazard(
    input logic       isLoadEx,
    input logic [4:0] rdEx,
    input logic [4:0] rsDec,
    input logic [4:0] rtDec,
    input logic       usesRtDec
  );
    return isLoadEx && (rdEx != 5'd0) &&
           ((rsDec == rdEx) || (usesRtDec && (rtDec == rdEx)));
  endfunction

endpackage

// File: rtl/hazard_cycle_counter.sv
// ---------------------------------------------------------------------------
// hazard_cycle_counter
// Small loadable saturating counter used for stall bookkeeping.
//   clk         in  1      rising-edge clock
//   reset_n     in  1      asynchronous active-low reset, clears the count
//   load_i      in  1      load loadValue_i (wins over enable_i)
//   loadValue_i in  WIDTH  value to load
//   enable_i    in  1      step once: up to LIMIT, or down to zero
//   count_o     out WIDTH  current count
//   terminal_o  out 1      count sits at its end stop (LIMIT up, 0 down)
// ---------------------------------------------------------------------------
module hazard_cycle_counter #(
  parameter int WIDTH    = 2,
  parameter int LIMIT    = 3,
  parameter bit COUNT_UP = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             terminal_o
);

  localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  // The counter never wraps: it parks at its end stop until reloaded.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (enable_i) begin
      if (COUNT_UP) begin
        if (count_q != LIMIT_C) count_d = count_q + ONE_C;
      end else begin
        if (count_q != '0) count_d = count_q - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o    = count_q;
  assign terminal_o = COUNT_UP ? (count_q == LIMIT_C) : (count_q == '0);

endmodule

// File: rtl/pipeline_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_control_unit
// Stall/flush controller for the 5-stage MIPS pipeline. Handles the hazards
// forwarding cannot: load-use, taken branch / jump squash, and a multi-cycle
// data memory. All controls are combinational from state + inputs, so a
// hazard is acted on in the cycle it is detected.
//   clk, reset_n                         clock, async active-low reset
//   addressRead{A,B}RegisterFile_Decode  rs / rt of the Decode instruction
//   usesRegisterB_Decode                 Decode instruction reads rt
//   jump_Decode                          jump resolved in Decode
//   enableReadDataMemory_Execute         Execute instruction is a load
//   addressWriteRegisterFile_Execute     destination of Execute instruction
//   branchTaken_Execute                  taken branch in Execute
//   dataMemoryBusy_MemoryAccess          data memory not ready
//   stall*/flush*/bubble*_HazardUnit     pipeline register hold/bubble controls
//   hazardState_HazardUnit               state (RUN=0, LOAD_STALL=1, MEM_WAIT=2)
//   memTimeoutError_HazardUnit           sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] addressReadARegisterFile_Decode,
  input  logic [4:0] addressReadBRegisterFile_Decode,
  input  logic       usesRegisterB_Decode,
  input  logic       jump_Decode,
  input  logic       enableReadDataMemory_Execute,
  input  logic [4:0] addressWriteRegisterFile_Execute,
  input  logic       branchTaken_Execute,
  input  logic       dataMemoryBusy_MemoryAccess,
  output logic       stallFetch_HazardUnit,
  output logic       stallDecode_HazardUnit,
  output logic       flushDecode_HazardUnit,
  output logic       flushExecute_HazardUnit,
  output logic       stallExecute_HazardUnit,
  output logic       stallMemoryAccess_HazardUnit,
  output logic       bubbleWriteBack_HazardUnit,
  output logic [1:0] hazardState_HazardUnit,
  output logic       memTimeoutError_HazardUnit
);

  if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > LOAD_USE_BUBBLES_MAX) begin : gBadBubbles
    $error("LOAD_USE_BUBBLES must be in 1..%0d", LOAD_USE_BUBBLES_MAX);
  end
  if (MEM_TIMEOUT < 1) begin : gBadTimeout
    $error("MEM_TIMEOUT must be at least 1");
  end

  localparam int                   WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BUB_CNT_W-1:0] BUB_RELOAD   = BUB_CNT_W'(LOAD_USE_BUBBLES - 1);
  localparam logic [BUB_CNT_W-1:0] BUB_LAST     = BUB_CNT_W'(1);
  localparam logic [WAIT_W-1:0]    WAIT_FIRST   = WAIT_W'(1);
  localparam logic                 MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

  hazard_state_t state_q, state_d;
  logic          err_q, err_d;
  logic          block_q, block_d;

  logic                 loadUse;
  logic                 effBusy;
  logic                 runStall, runFlushD, runFlushE, runStartLS;
  logic                 holdAll, stallFD, flushD, flushE, timeoutNow;
  logic                 bubLoad, bubDec, bubZero;
  logic [BUB_CNT_W-1:0] bubCnt;
  logic                 waitLoad, waitInc, waitAtLimit;
  logic [WAIT_W-1:0]    waitLoadVal, waitCnt;

  assign loadUse = loadUseHazard(enableReadDataMemory_Execute,
                                 addressWriteRegisterFile_Execute,
                                 addressReadARegisterFile_Decode,
                                 addressReadBRegisterFile_Decode,
                                 usesRegisterB_Decode);

  // After a forced timeout release the busy line is ignored until it has
  // been seen low once, otherwise a stuck memory would re-trap us forever.
  assign effBusy = dataMemoryBusy_MemoryAccess & ~block_q;

  // Normal-flow decision, shared by RUN and by the cycle that leaves
  // MEM_WAIT. Only the highest-priority event acts; the rest are dropped
  // and Decode re-evaluates next cycle.
  always_comb begin
    runStall   = 1'b0;
    runFlushD  = 1'b0;
    runFlushE  = 1'b0;
    runStartLS = 1'b0;
    if (branchTaken_Execute) begin
      runFlushD = 1'b1;
      runFlushE = 1'b1;
    end else if (loadUse) begin
      runStall   = 1'b1;
      runFlushE  = 1'b1;
      runStartLS = MULTI_BUBBLE;
    end else if (jump_Decode) begin
      runFlushD = 1'b1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    block_d     = block_q & dataMemoryBusy_MemoryAccess;
    holdAll     = 1'b0;
    stallFD     = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    timeoutNow  = 1'b0;
    bubLoad     = 1'b0;
    bubDec      = 1'b0;
    waitLoad    = 1'b0;
    waitLoadVal = '0;
    waitInc     = 1'b0;

    case (state_q)
      HZ_LOAD_STALL: begin
        // Branch/jump are ignored: EX carries a bubble and Decode is frozen.
        // A memory stall freezes the remaining-bubble count.
        if (effBusy) begin
          holdAll     = 1'b1;
          waitLoad    = 1'b1;
          waitLoadVal = WAIT_FIRST;
          state_d     = HZ_MEM_WAIT;
        end else begin
          stallFD = 1'b1;
          flushE  = 1'b1;
          bubDec  = 1'b1;
          if (bubCnt == BUB_LAST || bubZero) state_d = HZ_RUN;
        end
      end

      HZ_MEM_WAIT: begin
        if (dataMemoryBusy_MemoryAccess && !waitAtLimit) begin
          holdAll = 1'b1;
          waitInc = 1'b1;
        end else begin
          // Release cycle: either memory became ready or it timed out.
          // The pipe moves this cycle under the normal-flow rules.
          timeoutNow = dataMemoryBusy_MemoryAccess;
          if (timeoutNow) begin
            err_d   = 1'b1;
            block_d = 1'b1;
          end
          stallFD  = runStall;
          flushD   = runFlushD;
          flushE   = runFlushE;
          waitLoad = 1'b1;
          // An interrupted load stall resumes with its frozen count.
          if (!bubZero) begin
            state_d = HZ_LOAD_STALL;
          end else if (runStartLS) begin
            bubLoad = 1'b1;
            state_d = HZ_LOAD_STALL;
          end else begin
            state_d = HZ_RUN;
          end
        end
      end

      default: begin
        // HZ_RUN, and the unused encoding which behaves as RUN.
        state_d = HZ_RUN;
        if (effBusy) begin
          holdAll     = 1'b1;
          waitLoad    = 1'b1;
          waitLoadVal = WAIT_FIRST;
          state_d     = HZ_MEM_WAIT;
        end else begin
          stallFD = runStall;
          flushD  = runFlushD;
          flushE  = runFlushE;
          if (runStartLS) begin
            bubLoad = 1'b1;
            state_d = HZ_LOAD_STALL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HZ_RUN;
      err_q   <= 1'b0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      block_q <= block_d;
    end
  end

  hazard_cycle_counter #(
    .WIDTH   (BUB_CNT_W),
    .LIMIT   (LOAD_USE_BUBBLES_MAX),
    .COUNT_UP(1'b0)
  ) uBubbleCounter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (bubLoad),
    .loadValue_i(BUB_RELOAD),
    .enable_i   (bubDec),
    .count_o    (bubCnt),
    .terminal_o (bubZero)
  );

  hazard_cycle_counter #(
    .WIDTH   (WAIT_W),
    .LIMIT   (MEM_TIMEOUT),
    .COUNT_UP(1'b1)
  ) uWaitCounter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (waitLoad),
    .loadValue_i(waitLoadVal),
    .enable_i   (waitInc),
    .count_o    (waitCnt),
    .terminal_o (waitAtLimit)
  );

  // Outputs are gated by reset so every control drops the instant reset
  // asserts, independent of the inputs.
  assign stallFetch_HazardUnit        = reset_n & (holdAll | stallFD);
  assign stallDecode_HazardUnit       = reset_n & (holdAll | stallFD);
  assign flushDecode_HazardUnit       = reset_n & flushD;
  assign flushExecute_HazardUnit      = reset_n & flushE;
  assign stallExecute_HazardUnit      = reset_n & holdAll;
  assign stallMemoryAccess_HazardUnit = reset_n & holdAll;
  assign bubbleWriteBack_HazardUnit   = reset_n & holdAll;
  assign hazardState_HazardUnit       = state_q;
  assign memTimeoutError_HazardUnit   = reset_n & (err_q | timeoutNow);

endmodule

// File: tb/tb_pipeline_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_control_unit
// Drives three configurations of the hazard unit from one shared input set
// and compares every output each cycle against a behavioural model.
//   dut0: LOAD_USE_BUBBLES=1, MEM_TIMEOUT=15
//   dut1: LOAD_USE_BUBBLES=3, MEM_TIMEOUT=3
//   dut2: LOAD_USE_BUBBLES=2, MEM_TIMEOUT=1
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_control_unit;

  localparam int NUM_DUT = 3;
  localparam int M_RUN   = 0;
  localparam int M_LOAD  = 1;
  localparam int M_WAIT  = 2;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic [4:0] rsDec    = '0;
  logic [4:0] rtDec    = '0;
  logic [4:0] rdEx     = '0;
  logic       useB     = 1'b0;
  logic       jumpDec  = 1'b0;
  logic       loadEx   = 1'b0;
  logic       branchEx = 1'b0;
  logic       memBusy  = 1'b0;

  logic       stallF [NUM_DUT];
  logic       stallD [NUM_DUT];
  logic       flushD [NUM_DUT];
  logic       flushE [NUM_DUT];
  logic       stallE [NUM_DUT];
  logic       stallM [NUM_DUT];
  logic       bubWB  [NUM_DUT];
  logic       errO   [NUM_DUT];
  logic [1:0] st     [NUM_DUT];

  int lubP [NUM_DUT] = '{1, 3, 2};
  int mtP  [NUM_DUT] = '{15, 3, 1};

  // Model state: mode, bubbles still owed, busy cycles already absorbed,
  // latched error, and "busy must be seen low first" after a timeout.
  int mode        [NUM_DUT];
  int pending     [NUM_DUT];
  int busyRun     [NUM_DUT];
  bit latched     [NUM_DUT];
  bit mustSeeIdle [NUM_DUT];

  int checks    = 0;
  int errors    = 0;
  int cycle     = 0;
  int burstLeft = 0;

  always #5 clk = ~clk;

  pipeline_hazard_control_unit #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(15)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .addressReadARegisterFile_Decode(rsDec), .addressReadBRegisterFile_Decode(rtDec),
    .usesRegisterB_Decode(useB), .jump_Decode(jumpDec),
    .enableReadDataMemory_Execute(loadEx), .addressWriteRegisterFile_Execute(rdEx),
    .branchTaken_Execute(branchEx), .dataMemoryBusy_MemoryAccess(memBusy),
    .stallFetch_HazardUnit(stallF[0]), .stallDecode_HazardUnit(stallD[0]),
    .flushDecode_HazardUnit(flushD[0]), .flushExecute_HazardUnit(flushE[0]),
    .stallExecute_HazardUnit(stallE[0]), .stallMemoryAccess_HazardUnit(stallM[0]),
    .bubbleWriteBack_HazardUnit(bubWB[0]), .hazardState_HazardUnit(st[0]),
    .memTimeoutError_HazardUnit(errO[0])
  );

  pipeline_hazard_control_unit #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(3)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .addressReadARegisterFile_Decode(rsDec), .addressReadBRegisterFile_Decode(rtDec),
    .usesRegisterB_Decode(useB), .jump_Decode(jumpDec),
    .enableReadDataMemory_Execute(loadEx), .addressWriteRegisterFile_Execute(rdEx),
    .branchTaken_Execute(branchEx), .dataMemoryBusy_MemoryAccess(memBusy),
    .stallFetch_HazardUnit(stallF[1]), .stallDecode_HazardUnit(stallD[1]),
    .flushDecode_HazardUnit(flushD[1]), .flushExecute_HazardUnit(flushE[1]),
    .stallExecute_HazardUnit(stallE[1]), .stallMemoryAccess_HazardUnit(stallM[1]),
    .bubbleWriteBack_HazardUnit(bubWB[1]), .hazardState_HazardUnit(st[1]),
    .memTimeoutError_HazardUnit(errO[1])
  );

  pipeline_hazard_control_unit #(.LOAD_USE_BUBBLES(2), .MEM_TIMEOUT(1)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .addressReadARegisterFile_Decode(rsDec), .addressReadBRegisterFile_Decode(rtDec),
    .usesRegisterB_Decode(useB), .jump_Decode(jumpDec),
    .enableReadDataMemory_Execute(loadEx), .addressWriteRegisterFile_Execute(rdEx),
    .branchTaken_Execute(branchEx), .dataMemoryBusy_MemoryAccess(memBusy),
    .stallFetch_HazardUnit(stallF[2]), .stallDecode_HazardUnit(stallD[2]),
    .flushDecode_HazardUnit(flushD[2]), .flushExecute_HazardUnit(flushE[2]),
    .stallExecute_HazardUnit(stallE[2]), .stallMemoryAccess_HazardUnit(stallM[2]),
    .bubbleWriteBack_HazardUnit(bubWB[2]), .hazardState_HazardUnit(st[2]),
    .memTimeoutError_HazardUnit(errO[2])
  );

  // Output bundle order: stallF stallD flushD flushE stallE stallM bubWB err state[1:0]
  function automatic logic [9:0] observe(input int k);
    return {stallF[k], stallD[k], flushD[k], flushE[k], stallE[k],
            stallM[k], bubWB[k], errO[k], st[k]};
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] observed,
                             input logic [9:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < NUM_DUT; k++) begin
      mode[k]        = M_RUN;
      pending[k]     = 0;
      busyRun[k]     = 0;
      latched[k]     = 1'b0;
      mustSeeIdle[k] = 1'b0;
    end
  endfunction

  // One cycle of the controller as described behaviourally: returns the
  // expected outputs for the current inputs and advances the model.
  function automatic logic [9:0] modelStep(input int k);
    bit hazard, busyEff, timeoutNow, hold, stall, fD, fE;
    bit rStall, rFD, rFE, rNew;
    int shownMode;
    hazard     = loadEx && (rdEx != 0) && ((rsDec == rdEx) || (useB && (rtDec == rdEx)));
    busyEff    = memBusy && !mustSeeIdle[k];
    timeoutNow = 1'b0;
    hold = 1'b0; stall = 1'b0; fD = 1'b0; fE = 1'b0;
    rStall = 1'b0; rFD = 1'b0; rFE = 1'b0; rNew = 1'b0;
    shownMode = mode[k];

    if (branchEx) begin
      rFD = 1'b1; rFE = 1'b1;
    end else if (hazard) begin
      rStall = 1'b1; rFE = 1'b1; rNew = (lubP[k] > 1);
    end else if (jumpDec) begin
      rFD = 1'b1;
    end

    if (mode[k] == M_WAIT) begin
      if (memBusy && busyRun[k] < mtP[k]) begin
        hold = 1'b1;
        busyRun[k]++;
      end else begin
        timeoutNow = memBusy;
        stall = rStall; fD = rFD; fE = rFE;
        busyRun[k] = 0;
        if (pending[k] > 0) mode[k] = M_LOAD;
        else if (rNew) begin pending[k] = lubP[k] - 1; mode[k] = M_LOAD; end
        else mode[k] = M_RUN;
      end
    end else if (busyEff) begin
      hold = 1'b1;
      busyRun[k] = 1;
      mode[k] = M_WAIT;
    end else if (mode[k] == M_LOAD) begin
      stall = 1'b1; fE = 1'b1;
      pending[k]--;
      if (pending[k] <= 0) begin pending[k] = 0; mode[k] = M_RUN; end
    end else begin
      stall = rStall; fD = rFD; fE = rFE;
      if (rNew) begin pending[k] = lubP[k] - 1; mode[k] = M_LOAD; end
    end

    mustSeeIdle[k] = (mustSeeIdle[k] && memBusy) || timeoutNow;
    modelStep = {hold | stall, hold | stall, fD, fE, hold, hold, hold,
                 latched[k] | timeoutNow, 2'(shownMode)};
    latched[k] = latched[k] | timeoutNow;
  endfunction

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic ub, input logic jmp, input logic ld,
                               input logic [4:0] rd, input logic br,
                               input logic busy, input string tag);
    logic [9:0] expected;
    @(negedge clk);
    rsDec = rs; rtDec = rt; useB = ub; jumpDec = jmp;
    loadEx = ld; rdEx = rd; branchEx = br; memBusy = busy;
    #1;
    for (int k = 0; k < NUM_DUT; k++) begin
      expected = modelStep(k);
      checkOutput($sformatf("%s/dut%0d/cyc%0d", tag, k, cycle), observe(k), expected);
    end
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic busyFor(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Reset with hazard-provoking inputs: every output must stay low.
  task automatic doReset();
    reset_n = 1'b0;
    rsDec = 5'd5; rtDec = 5'd5; useB = 1'b1; jumpDec = 1'b1;
    loadEx = 1'b1; rdEx = 5'd5; branchEx = 1'b1; memBusy = 1'b1;
    @(negedge clk);
    #1;
    for (int k = 0; k < NUM_DUT; k++)
      checkOutput($sformatf("reset/dut%0d", k), observe(k), 10'b0);
    @(negedge clk);
    rsDec = '0; rtDec = '0; useB = 1'b0; jumpDec = 1'b0;
    loadEx = 1'b0; rdEx = '0; branchEx = 1'b0; memBusy = 1'b0;
    reset_n = 1'b1;
    modelReset();
  endtask

  initial begin
    modelReset();
    doReset();

    // lw $5 in EX, Decode reads $5 through rs.
    applyStimulus(5, 0, 0, 0, 1, 5, 0, 0, "loadUse");
    idle(3);
    // Load to $0, and rt match while rt is not a source: no stall.
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, "loadUseR0");
    applyStimulus(2, 7, 0, 0, 1, 7, 0, 0, "rtNotUsed");
    applyStimulus(2, 7, 1, 0, 1, 7, 0, 0, "rtUsed");
    idle(3);
    // Taken branch outranks a simultaneous load-use.
    applyStimulus(5, 0, 0, 0, 1, 5, 1, 0, "branchLoadUse");
    idle(3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, "jump");
    idle(1);
    // Memory wait, then a long busy that times out the short-timeout units.
    busyFor(4, "memWait4");
    idle(2);
    busyFor(10, "memBusy10");
    idle(2);
    // Memory stall landing inside a multi-bubble load stall.
    applyStimulus(5, 0, 0, 0, 1, 5, 0, 0, "nestedLoad");
    busyFor(2, "nestedBusy");
    idle(4);
    // Branch frozen in EX during a memory wait must act after release.
    busyFor(2, "branchHeld");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, "branchHeld");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, "branchHeld");
    idle(2);

    // Asynchronous reset in the middle of a memory wait.
    busyFor(5, "preReset");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NUM_DUT; k++)
      checkOutput($sformatf("asyncReset/dut%0d", k), observe(k), 10'b0);
    @(negedge clk);
    memBusy = 1'b0;
    reset_n = 1'b1;
    modelReset();
    idle(2);

    // Randomized traffic with bursty memory-busy periods.
    for (int n = 0; n < 2500; n++) begin
      logic bsy;
      if (burstLeft > 0) begin
        bsy = 1'b1;
        burstLeft--;
      end else if ($urandom_range(0, 9) == 0) begin
        bsy = 1'b1;
        burstLeft = $urandom_range(0, 19);
      end else begin
        bsy = 1'b0;
      end
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), bsy, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
